// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// datapath select constants, opcode/funct values and the instruction class type.
package mc_controller_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   // PC source
   localparam logic [1:0] PCSEL_PC4  = 2'd0;
   localparam logic [1:0] PCSEL_BR   = 2'd1;
   localparam logic [1:0] PCSEL_JUMP = 2'd2;
   localparam logic [1:0] PCSEL_JR   = 2'd3;

   // GRF write address source
   localparam logic [1:0] A3SEL_RT = 2'd0;
   localparam logic [1:0] A3SEL_RD = 2'd1;
   localparam logic [1:0] A3SEL_RA = 2'd2;

   // GRF write data source
   localparam logic [1:0] WDSEL_ALU = 2'd0;
   localparam logic [1:0] WDSEL_DM  = 2'd1;
   localparam logic [1:0] WDSEL_PC4 = 2'd2;

   // ALU operation and operand B source
   localparam logic [2:0] ALUOP_ADD = 3'd0;
   localparam logic [2:0] ALUOP_SUB = 3'd1;
   localparam logic [2:0] ALUOP_OR  = 3'd2;
   localparam logic [2:0] ALUOP_LUI = 3'd3;
   localparam logic       ALUB_RD2  = 1'b0;
   localparam logic       ALUB_EXT  = 1'b1;

   // Immediate extension and data memory access width
   localparam logic       EXT_ZERO  = 1'b0;
   localparam logic       EXT_SIGN  = 1'b1;
   localparam logic [1:0] DMOP_WORD = 2'd0;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes (nop is the all-zero word, i.e. funct 0)
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_NOP = 6'b000000;

   // Instruction class, exactly one bit set for a supported instruction
   typedef struct packed {
      logic add;
      logic sub;
      logic jr;
      logic nop;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic j;
      logic jal;
   } cls_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       alub_sel;
      logic       ext_op;
   } alu_ctrl_t;

   // ALU/EXT selects for an instruction; held from EXEC through WB
   function automatic alu_ctrl_t alu_ctrl(input cls_t c);
      alu_ctrl_t r;
      r.alu_op   = ALUOP_ADD;
      r.alub_sel = ALUB_RD2;
      r.ext_op   = EXT_ZERO;
      if (c.sub || c.beq) begin
         r.alu_op = ALUOP_SUB;
      end
      if (c.ori) begin
         r.alu_op   = ALUOP_OR;
         r.alub_sel = ALUB_EXT;
      end
      if (c.lui) begin
         r.alu_op   = ALUOP_LUI;
         r.alub_sel = ALUB_EXT;
      end
      if (c.lw || c.sw) begin
         r.alub_sel = ALUB_EXT;
         r.ext_op   = EXT_SIGN;
      end
      return r;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class plus
// an illegal flag for anything outside the supported subset.
module mc_decode
   import mc_controller_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output cls_t       cls_o,
   output logic       illegal_o
);

   // Classify; an unmatched encoding leaves every class bit clear
   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD:  cls_o.add = 1'b1;
               FN_SUB:  cls_o.sub = 1'b1;
               FN_JR:   cls_o.jr  = 1'b1;
               FN_NOP:  cls_o.nop = 1'b1;
               default: cls_o     = '0;
            endcase
         end
         OP_ORI:  cls_o.ori = 1'b1;
         OP_LUI:  cls_o.lui = 1'b1;
         OP_LW:   cls_o.lw  = 1'b1;
         OP_SW:   cls_o.sw  = 1'b1;
         OP_BEQ:  cls_o.beq = 1'b1;
         OP_J:    cls_o.j   = 1'b1;
         OP_JAL:  cls_o.jal = 1'b1;
         default: cls_o     = '0;
      endcase
      illegal_o = (cls_o == '0);
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle sequencer for the MIPS datapath. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath selects and write enables,
// waits on the data memory handshake and counts retired instructions.
module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int MEM_TO_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             ALUflag_zero,
   input  logic             dm_ack,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic [1:0]       PCSel,
   output logic [1:0]       A3Sel,
   output logic [1:0]       WDSel,
   output logic [2:0]       ALUOp,
   output logic             ALUBSel,
   output logic             EXTOp,
   output logic [1:0]       DMOp,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             dm_req,
   output logic             illegal,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   // Wide enough to hold MEM_TO_MAX; a single bit when the limit is disabled
   localparam int WAIT_W = (MEM_TO_MAX < 1) ? 1 : $clog2(MEM_TO_MAX + 1);

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               retire;
   cls_t               cls;
   logic               dec_illegal;
   alu_ctrl_t          alu;

   mc_decode u_decode (
      .opcode_i  (opcode),
      .funct_i   (funct),
      .cls_o     (cls),
      .illegal_o (dec_illegal)
   );

   assign alu = alu_ctrl(cls);

   // Next state and per-state control outputs; reset forces every output low
   always_comb begin
      state_d  = state_q;
      retire   = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSel    = PCSEL_PC4;
      A3Sel    = A3SEL_RT;
      WDSel    = WDSEL_ALU;
      ALUOp    = ALUOP_ADD;
      ALUBSel  = ALUB_RD2;
      EXTOp    = EXT_ZERO;
      DMOp     = DMOP_WORD;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      dm_req   = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCSel   = PCSEL_PC4;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            // Jumps, nop and illegal complete here; everything else needs the ALU
            if (cls.j || cls.jal) begin
               PCWrite = 1'b1;
               PCSel   = PCSEL_JUMP;
            end
            if (cls.jal) begin
               RegWrite = 1'b1;
               A3Sel    = A3SEL_RA;
               WDSel    = WDSEL_PC4;
            end
            if (cls.jr) begin
               PCWrite = 1'b1;
               PCSel   = PCSEL_JR;
            end
            illegal = dec_illegal;
            if (cls.j || cls.jal || cls.jr || cls.nop || dec_illegal) begin
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            ALUOp   = alu.alu_op;
            ALUBSel = alu.alub_sel;
            EXTOp   = alu.ext_op;
            if (cls.beq) begin
               PCWrite = ALUflag_zero;
               PCSel   = PCSEL_BR;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end else if (cls.lw || cls.sw) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM: begin
            ALUOp    = alu.alu_op;
            ALUBSel  = alu.alub_sel;
            EXTOp    = alu.ext_op;
            dm_req   = 1'b1;
            MemWrite = cls.sw;
            if (dm_ack) begin
               if (cls.sw) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            ALUOp    = alu.alu_op;
            ALUBSel  = alu.alub_sel;
            EXTOp    = alu.ext_op;
            RegWrite = 1'b1;
            A3Sel    = (cls.add || cls.sub) ? A3SEL_RD : A3SEL_RT;
            WDSel    = cls.lw ? WDSEL_DM : WDSEL_ALU;
            retire   = 1'b1;
            state_d  = ST_FETCH;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
      if (reset) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         PCSel    = PCSEL_PC4;
         A3Sel    = A3SEL_RT;
         WDSel    = WDSEL_ALU;
         ALUOp    = ALUOP_ADD;
         ALUBSel  = ALUB_RD2;
         EXTOp    = EXT_ZERO;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         dm_req   = 1'b0;
         illegal  = 1'b0;
      end
   end

   // MEM wait counter (saturating, cleared outside MEM) and sticky timeout flag
   always_comb begin
      wait_d    = '0;
      timeout_d = timeout_q;
      if (state_q == ST_MEM && !dm_ack) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
         if (MEM_TO_MAX != 0 && (int'(wait_q) + 1) >= MEM_TO_MAX) begin
            timeout_d = 1'b1;
         end
      end
      retired_d = retire ? retired_q + 1'b1 : retired_q;
   end

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         retired_q <= retired_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign retired     = retired_q;
   assign state       = state_q;

endmodule
